// File: rtl/player_sprite_sched_pkg.sv
// -----------------------------------------------------------------------------
// sprite_sched_pkg
// Shared types and constants for the player sprite register scheduler:
//   - commit FSM state enum
//   - shadow register offsets inside the register space
//   - bus geometry and the address bit that selects the register space
//   - shadow register bundle and the slot address helper
// -----------------------------------------------------------------------------
package sprite_sched_pkg;

  localparam int BUS_AW        = 14;
  localparam int BUS_DW        = 32;
  localparam int REG_SPACE_BIT = 13;

  localparam logic [2:0] REG_BYP  = 3'd0;
  localparam logic [2:0] REG_X    = 3'd1;
  localparam logic [2:0] REG_Y    = 3'd2;
  localparam logic [2:0] REG_SEL  = 3'd3;
  localparam logic [2:0] REG_KICK = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_W_BYP,
    ST_W_X,
    ST_W_Y,
    ST_W_SEL
  } sched_state_t;

  typedef struct packed {
    logic        bypass;
    logic [10:0] x0;
    logic [10:0] y0;
    logic        sel;
  } shadow_t;

  // Slot address of a sprite core register: register space bit plus offset.
  function automatic logic [BUS_AW-1:0] slot_reg_addr(input logic [2:0] off);
    logic [BUS_AW-1:0] a;
    a                = '0;
    a[REG_SPACE_BIT] = 1'b1;
    a[1:0]           = off[1:0];
    return a;
  endfunction

endpackage

// File: rtl/player_sprite_sched_if.sv
// -----------------------------------------------------------------------------
// player_sprite_sched_if
// Write-only video slot bus. Used twice by the scheduler: once facing the CPU
// (slave modport) and once facing the sprite core (master modport).
//   cs      : chip select
//   write   : write strobe
//   addr    : 14-bit slot address, bit 13 selects the register space
//   wr_data : 32-bit write data
// -----------------------------------------------------------------------------
interface player_sprite_sched_if;
  import sprite_sched_pkg::*;

  logic              cs;
  logic              write;
  logic [BUS_AW-1:0] addr;
  logic [BUS_DW-1:0] wr_data;

  modport master (output cs, write, addr, wr_data);
  modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/player_sprite_sched_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// One-cycle registered pulse on the first clock where the frame counter sits
// at x == 0, y == V_ACTIVE (start of vertical blank).
//   clk, reset_n : clock, synchronous active-low reset
//   x, y         : frame counter position
//   frame_tick   : registered pulse, once per frame
// -----------------------------------------------------------------------------
module frame_tick_gen #(
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        frame_tick
);

  logic at_vblank;
  logic at_vblank_q;

  assign at_vblank = (x == 11'd0) && (y == 11'(V_ACTIVE));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      at_vblank_q <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      at_vblank_q <= at_vblank;
      // Rising edge only: the counter may dwell on the vblank position.
      frame_tick  <= at_vblank & ~at_vblank_q;
    end
  end

endmodule

// File: rtl/player_sprite_sched.sv
// -----------------------------------------------------------------------------
// player_sprite_sched
// Frame-synchronous register scheduler for one player sprite core. RAM writes
// pass straight to the core one cycle later; bypass/x0/y0/sel writes land in
// shadow registers and are committed as a four-write burst at vertical blank.
//
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   x, y             : frame counter position
//   kick             : single-cycle kick request from game logic
//   cpu (slave)      : CPU video-slot bus
//   sp  (master)     : slot bus to the sprite core (registered)
//   busy             : commit burst in progress
//   frame_tick       : one-cycle pulse per frame
//
// Build option: SPRITE_KICK_ANIM_EN adds the kick timer that forces sel high
// for KICK_FRAMES frames. Without it the kick port and kick address are inert.
// -----------------------------------------------------------------------------
module player_sprite_sched
  import sprite_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int V_ACTIVE    = 480,
  parameter int KICK_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  kick,
  player_sprite_sched_if.slave  cpu,
  player_sprite_sched_if.master sp,
  output logic                  busy,
  output logic                  frame_tick
);

  logic              ram_req;
  logic              reg_wr;
  logic              shadow_wr;
  logic              start;
  logic              eff_sel;
  logic              kick_dirty;
  logic [BUS_AW-1:0] ram_addr;
  shadow_t           shadow;
  shadow_t           snap;
  logic              dirty;
  sched_state_t      state;
  sched_state_t      state_nxt;
  logic              cs_d;
  logic [BUS_AW-1:0] addr_d;
  logic [BUS_DW-1:0] data_d;

  assign ram_req   = cpu.cs & cpu.write & ~cpu.addr[REG_SPACE_BIT];
  assign reg_wr    = cpu.cs & cpu.write &  cpu.addr[REG_SPACE_BIT];
  assign shadow_wr = reg_wr & ~cpu.addr[2];  // offsets 0..3
  assign start     = (state == ST_IDLE) & frame_tick & dirty;

  // Sprite RAM word address plus the upper select bits, forwarded unchanged.
  assign ram_addr = {cpu.addr[BUS_AW-1:ADDR_WIDTH], cpu.addr[ADDR_WIDTH-1:0]};

  frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_frame_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick)
  );

`ifdef SPRITE_KICK_ANIM_EN
  logic [7:0] kick_cnt;
  logic       kick_evt;
  logic       kick_expire;

  assign kick_evt    = kick | (reg_wr & (cpu.addr[2:0] == REG_KICK));
  // A reload in the same cycle pre-empts expiry.
  assign kick_expire = frame_tick & (kick_cnt == 8'd1) & ~kick_evt;
  assign kick_dirty  = kick_evt | kick_expire;
  assign eff_sel     = shadow.sel | (kick_cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kick_cnt <= 8'd0;
    end else if (kick_evt) begin
      kick_cnt <= 8'(KICK_FRAMES);
    end else if (frame_tick && kick_cnt != 8'd0) begin
      kick_cnt <= kick_cnt - 8'd1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = kick ^ KICK_FRAMES[0] ^ (cpu.addr[2:0] == REG_KICK);
  assign kick_dirty = 1'b0;
  assign eff_sel    = shadow.sel;
`endif

  // Shadows, snapshot and dirty flag. The snapshot is taken on the edge into
  // SNAP so it is stable for the whole burst while the CPU keeps writing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
      snap   <= '0;
      dirty  <= 1'b0;
    end else begin
      if (shadow_wr) begin
        case (cpu.addr[2:0])
          REG_BYP: shadow.bypass <= cpu.wr_data[0];
          REG_X:   shadow.x0     <= cpu.wr_data[10:0];
          REG_Y:   shadow.y0     <= cpu.wr_data[10:0];
          REG_SEL: shadow.sel    <= cpu.wr_data[0];
          default: ;
        endcase
      end
      if (start) begin
        snap <= '{bypass: shadow.bypass, x0: shadow.x0, y0: shadow.y0, sel: eff_sel};
      end
      // A write in the snapshot cycle must survive the clear.
      if (shadow_wr || kick_dirty) begin
        dirty <= 1'b1;
      end else if (start) begin
        dirty <= 1'b0;
      end
    end
  end

  // The state names the register write currently on the sprite bus. Outputs
  // are registered from the next state, so a CPU RAM write simply holds the
  // state and the pending register write goes out one cycle later.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cs_d      = 1'b0;
    addr_d    = '0;
    data_d    = '0;

    case (state)
      ST_IDLE:  if (start)    state_nxt = ST_SNAP;
      ST_SNAP:  if (!ram_req) state_nxt = ST_W_BYP;
      ST_W_BYP: if (!ram_req) state_nxt = ST_W_X;
      ST_W_X:   if (!ram_req) state_nxt = ST_W_Y;
      ST_W_Y:   if (!ram_req) state_nxt = ST_W_SEL;
      ST_W_SEL: state_nxt = ST_IDLE;  // nothing left to issue
      default:  state_nxt = ST_IDLE;
    endcase

    if (ram_req) begin
      cs_d   = 1'b1;
      addr_d = ram_addr;
      data_d = cpu.wr_data;
    end else begin
      case (state_nxt)
        ST_W_BYP: begin
          cs_d   = 1'b1;
          addr_d = slot_reg_addr(REG_BYP);
          data_d = {31'd0, snap.bypass};
        end
        ST_W_X: begin
          cs_d   = 1'b1;
          addr_d = slot_reg_addr(REG_X);
          data_d = {21'd0, snap.x0};
        end
        ST_W_Y: begin
          cs_d   = 1'b1;
          addr_d = slot_reg_addr(REG_Y);
          data_d = {21'd0, snap.y0};
        end
        ST_W_SEL: begin
          cs_d   = 1'b1;
          addr_d = slot_reg_addr(REG_SEL);
          data_d = {30'd0, snap.sel, 1'b0};  // core reads sel on bit 1
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      sp.cs      <= 1'b0;
      sp.write   <= 1'b0;
      sp.addr    <= '0;
      sp.wr_data <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      sp.cs      <= cs_d;
      sp.write   <= cs_d;
      sp.addr    <= addr_d;
      sp.wr_data <= data_d;
    end
  end

endmodule

// File: tb/tb_player_sprite_sched.sv
// -----------------------------------------------------------------------------
// tb_player_sprite_sched
// Self-checking bench: a table of single-cycle bus vectors, hand-written
// sequences for the multi-cycle cases, and a randomized run compared against
// a queue-based behavioural model of the commit rules.
// -----------------------------------------------------------------------------
module tb_player_sprite_sched;

  localparam int V_ACTIVE    = 480;
  localparam int KICK_FRAMES = 2;
`ifdef SPRITE_KICK_ANIM_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] x = 11'd5;
  logic [10:0] y = 11'd5;
  logic        kick = 1'b0;
  logic        busy;
  logic        frame_tick;

  player_sprite_sched_if cpu_bus ();
  player_sprite_sched_if sp_bus ();

  player_sprite_sched #(
    .ADDR_WIDTH  (11),
    .V_ACTIVE    (V_ACTIVE),
    .KICK_FRAMES (KICK_FRAMES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .kick       (kick),
    .cpu        (cpu_bus),
    .sp         (sp_bus),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input logic cs, input logic wr, input logic [13:0] a,
                           input logic [31:0] d);
    cpu_bus.cs      = cs;
    cpu_bus.write   = wr;
    cpu_bus.addr    = a;
    cpu_bus.wr_data = d;
  endtask

  task automatic bus_idle();
    drive_bus(1'b0, 1'b0, 14'h0000, 32'h0);
    kick = 1'b0;
  endtask

  task automatic reset_dut();
    bus_idle();
    x = 11'd5;
    y = 11'd5;
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic reg_write(input logic [2:0] off, input logic [31:0] d);
    drive_bus(1'b1, 1'b1, 14'h2000 | 14'(off), d);
    cyc();
    bus_idle();
  endtask

  // Leaves the bench in cycle T (frame_tick visible).
  task automatic fire_vblank(input string name);
    x = 11'd0;
    y = 11'(V_ACTIVE);
    cyc();
    x = 11'd5;
    y = 11'(V_ACTIVE + 1);
    check({name, ".tick"}, frame_tick, 1'b1);
  endtask

  task automatic expect_wr(input string name, input logic [13:0] a, input logic [31:0] d);
    check({name, ".cs"}, sp_bus.cs, 1'b1);
    check({name, ".write"}, sp_bus.write, 1'b1);
    check({name, ".addr"}, sp_bus.addr, a);
    check({name, ".data"}, sp_bus.wr_data, d);
  endtask

  // Called in cycle T; walks T..T+6 of an uncontended burst.
  task automatic expect_burst(input string name, input logic byp, input logic [10:0] x0,
                              input logic [10:0] y0, input logic sel);
    check({name, ".busy_T"}, busy, 1'b0);
    cyc();
    check({name, ".busy_T1"}, busy, 1'b1);
    check({name, ".cs_T1"}, sp_bus.cs, 1'b0);
    cyc(); expect_wr({name, ".byp"}, 14'h2000, {31'd0, byp});
    cyc(); expect_wr({name, ".x"},   14'h2001, {21'd0, x0});
    cyc(); expect_wr({name, ".y"},   14'h2002, {21'd0, y0});
    cyc(); expect_wr({name, ".sel"}, 14'h2003, {30'd0, sel, 1'b0});
    check({name, ".busy_T5"}, busy, 1'b1);
    cyc();
    check({name, ".busy_T6"}, busy, 1'b0);
    check({name, ".cs_T6"}, sp_bus.cs, 1'b0);
  endtask

  task automatic expect_no_commit(input string name);
    for (int i = 0; i < 7; i++) begin
      check({name, ".busy"}, busy, 1'b0);
      check({name, ".cs"}, sp_bus.cs, 1'b0);
      cyc();
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         pend[$];
  logic        m_byp, m_sel, m_dirty, m_prev_at;
  logic [10:0] m_x0, m_y0;
  int          m_kick;
  logic        e_cs, e_busy, e_tick;
  logic [13:0] e_addr;
  logic [31:0] e_data;

  task automatic model_reset();
    pend.delete();
    m_byp = 0; m_sel = 0; m_dirty = 0; m_prev_at = 0;
    m_x0 = 0; m_y0 = 0; m_kick = 0;
    e_cs = 0; e_busy = 0; e_tick = 0; e_addr = 0; e_data = 0;
  endtask

  // Advances the model across one clock edge using the inputs now driven.
  task automatic model_step();
    logic ram, regw, start, kick_evt, set_dirty, nb, at, eff;
    logic [2:0] off;
    wr_t w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ram   = cpu_bus.cs & cpu_bus.write & ~cpu_bus.addr[13];
    regw  = cpu_bus.cs & cpu_bus.write &  cpu_bus.addr[13];
    off   = cpu_bus.addr[2:0];
    start = e_tick && m_dirty && !e_busy;
    nb    = start || (e_busy && pend.size() > 0);

    e_cs = 0;
    if (ram) begin
      e_cs = 1; e_addr = cpu_bus.addr; e_data = cpu_bus.wr_data;
    end else if (e_busy && pend.size() > 0) begin
      w = pend.pop_front();
      e_cs = 1; e_addr = w.addr; e_data = w.data;
    end

    if (start) begin
      eff = m_sel || (KICK_EN && m_kick > 0);
      pend.push_back('{14'h2000, {31'd0, m_byp}});
      pend.push_back('{14'h2001, {21'd0, m_x0}});
      pend.push_back('{14'h2002, {21'd0, m_y0}});
      pend.push_back('{14'h2003, {30'd0, eff, 1'b0}});
    end

    set_dirty = regw && off < 3'd4;
    kick_evt  = KICK_EN && (kick || (regw && off == 3'd4));
    if (kick_evt) begin
      m_kick = KICK_FRAMES;
      set_dirty = 1;
    end else if (e_tick && m_kick > 0) begin
      m_kick--;
      if (m_kick == 0) set_dirty = 1;
    end
    if (regw) begin
      case (off)
        3'd0: m_byp = cpu_bus.wr_data[0];
        3'd1: m_x0  = cpu_bus.wr_data[10:0];
        3'd2: m_y0  = cpu_bus.wr_data[10:0];
        3'd3: m_sel = cpu_bus.wr_data[0];
        default: ;
      endcase
    end
    if (set_dirty) m_dirty = 1;
    else if (start) m_dirty = 0;

    e_busy    = nb;
    at        = (x == 11'd0) && (y == 11'(V_ACTIVE));
    e_tick    = at && !m_prev_at;
    m_prev_at = at;
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic        cs;
    logic        wr;
    logic [13:0] addr;
    logic [31:0] data;
    logic        exp_cs;
    logic [13:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 14'h0000, 32'hDEADBEEF, 1'b1, 14'h0000, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 14'h1FFF, 32'hFFFFFFFF, 1'b1, 14'h1FFF, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 1'b0, 14'h0123, 32'h00000011, 1'b0, 14'h0000, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 14'h0123, 32'h00000022, 1'b0, 14'h0000, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 14'h2001, 32'h00000005, 1'b0, 14'h0000, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 14'h2007, 32'hFFFFFFFF, 1'b0, 14'h0000, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 14'h0AAA, 32'h12345678, 1'b1, 14'h0AAA, 32'h12345678};
    vecs[7] = '{1'b1, 1'b1, 14'h2004, 32'hFFFFFFFF, 1'b0, 14'h0000, 32'h0};

    // Reset state.
    reset_dut();
    check("rst.cs", sp_bus.cs, 1'b0);
    check("rst.write", sp_bus.write, 1'b0);
    check("rst.addr", sp_bus.addr, 14'h0);
    check("rst.data", sp_bus.wr_data, 32'h0);
    check("rst.busy", busy, 1'b0);
    check("rst.tick", frame_tick, 1'b0);

    // Table: one bus cycle each, output one cycle later.
    foreach (vecs[i]) begin
      drive_bus(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].data);
      cyc();
      bus_idle();
      check($sformatf("vec%0d.cs", i), sp_bus.cs, vecs[i].exp_cs);
      if (vecs[i].exp_cs) expect_wr($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_data);
      check($sformatf("vec%0d.busy", i), busy, 1'b0);
    end
    // Shadows from the table: x0=5, 0x2007 ignored, 0x2004 kicks when enabled.
    fire_vblank("tbl");
    expect_burst("tbl", 1'b0, 11'd5, 11'd0, KICK_EN);

    // Basic commit.
    reset_dut();
    y = 11'd100;
    reg_write(3'd1, 32'd100);
    reg_write(3'd2, 32'd200);
    cyc();
    fire_vblank("basic");
    expect_burst("basic", 1'b0, 11'd100, 11'd200, 1'b0);

    // RAM write during the burst pushes the remaining writes back one cycle.
    reset_dut();
    reg_write(3'd1, 32'd7);
    fire_vblank("ramb");
    cyc(); check("ramb.busy_T1", busy, 1'b1);
    cyc(); expect_wr("ramb.byp", 14'h2000, 32'd0);
    cyc(); expect_wr("ramb.x", 14'h2001, 32'd7);
    drive_bus(1'b1, 1'b1, 14'h0005, 32'd3);
    cyc(); bus_idle();
    expect_wr("ramb.ram", 14'h0005, 32'd3);
    check("ramb.busy_T4", busy, 1'b1);
    cyc(); expect_wr("ramb.y", 14'h2002, 32'd0);
    cyc(); expect_wr("ramb.sel", 14'h2003, 32'd0);
    check("ramb.busy_T6", busy, 1'b1);
    cyc();
    check("ramb.busy_T7", busy, 1'b0);
    check("ramb.cs_T7", sp_bus.cs, 1'b0);

    // Shadow write during the burst commits at the next frame.
    reset_dut();
    reg_write(3'd1, 32'd50);
    fire_vblank("shb");
    cyc();
    cyc(); expect_wr("shb.byp", 14'h2000, 32'd0);
    drive_bus(1'b1, 1'b1, 14'h2001, 32'd300);
    cyc(); bus_idle();
    expect_wr("shb.x_old", 14'h2001, 32'd50);
    cyc(); cyc(); cyc();
    check("shb.busy_end", busy, 1'b0);
    fire_vblank("shb2");
    expect_burst("shb2", 1'b0, 11'd300, 11'd0, 1'b0);

    // Kick timer.
    reset_dut();
    kick = 1'b1;
    cyc();
    kick = 1'b0;
`ifdef SPRITE_KICK_ANIM_EN
    fire_vblank("kick1");
    expect_burst("kick1", 1'b0, 11'd0, 11'd0, 1'b1);
    fire_vblank("kick2");
    expect_no_commit("kick2");
    fire_vblank("kick3");
    expect_burst("kick3", 1'b0, 11'd0, 11'd0, 1'b0);
    fire_vblank("kick4");
    expect_no_commit("kick4");
`else
    reg_write(3'd4, 32'd1);
    fire_vblank("kick_off");
    expect_no_commit("kick_off");
`endif

    // No change: three quiet frames; tick fires once while the counter dwells.
    reset_dut();
    for (int f = 0; f < 3; f++) begin
      x = 11'd0;
      y = 11'(V_ACTIVE);
      cyc(); check("dwell.tick0", frame_tick, 1'b1);
      cyc(); check("dwell.tick1", frame_tick, 1'b0);
      cyc(); check("dwell.tick2", frame_tick, 1'b0);
      x = 11'd5;
      y = 11'(V_ACTIVE + 1);
      expect_no_commit("quiet");
    end

    // Reset mid-burst aborts and nothing commits afterwards.
    reset_dut();
    reg_write(3'd1, 32'd9);
    fire_vblank("rstb");
    cyc();
    cyc(); expect_wr("rstb.byp", 14'h2000, 32'd0);
    cyc(); expect_wr("rstb.x", 14'h2001, 32'd9);
    reset_n = 1'b0;
    cyc();
    check("rstb.cs", sp_bus.cs, 1'b0);
    check("rstb.busy", busy, 1'b0);
    check("rstb.addr", sp_bus.addr, 14'h0);
    reset_n = 1'b1;
    cyc();
    cyc();
    fire_vblank("rstb2");
    expect_no_commit("rstb2");

    // Randomized run against the model.
    reset_dut();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      check("rnd.cs", sp_bus.cs, e_cs);
      check("rnd.write", sp_bus.write, e_cs);
      if (e_cs) begin
        check("rnd.addr", sp_bus.addr, e_addr);
        check("rnd.data", sp_bus.wr_data, e_data);
      end
      check("rnd.busy", busy, e_busy);
      check("rnd.tick", frame_tick, e_tick);

      reset_n = ($urandom_range(0, 699) != 0);
      r = $urandom_range(0, 99);
      if (r < 20)
        drive_bus(1'b1, 1'b1, {1'b0, 13'($urandom)}, $urandom);
      else if (r < 36)
        drive_bus(1'b1, 1'b1, {1'b1, 10'($urandom), 3'($urandom)}, $urandom);
      else if (r < 40)
        drive_bus(1'b1, 1'b0, 14'($urandom), $urandom);
      else if (r < 43)
        drive_bus(1'b0, 1'b1, 14'($urandom), $urandom);
      else
        drive_bus(1'b0, 1'b0, 14'h0, 32'h0);
      kick = ($urandom_range(0, 59) == 0);
      if (x == 11'd0 && y == 11'(V_ACTIVE) && $urandom_range(0, 1) == 1) begin
        // dwell on the vblank position
      end else if ($urandom_range(0, 13) == 0) begin
        x = 11'd0;
        y = 11'(V_ACTIVE);
      end else begin
        x = 11'($urandom_range(0, 2047));
        y = 11'($urandom_range(0, 2047));
      end
      model_step();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
